con4_board_ctrl: RTL

//  Owns the Connect-4 board state that feeds the VGA driver's con4_matrix input.

---
 rtl/con4_board_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/con4_board_ctrl.sv
// con4_board_ctrl: Connect-4 board owner; gravity drop via sequential column scan, optional win check.
// Define CON4_WIN_CHECK_EN to build the four-direction CHECK state (adds 4 cycles per placement).
module con4_board_ctrl #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int CONNECT = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              drop_valid,
    output logic                              drop_ready,
    input  logic [2:0]                        drop_col,
    input  logic [1:0]                        drop_player,
    output logic                              done_valid,
    output logic [1:0]                        done_status,
    output logic [2:0]                        done_row,
    output logic [0:ROWS-1][0:COLS-1][1:0]    board,
    output logic [1:0]                        winner,
    output logic                              game_over,
    output logic                              board_full
);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
    localparam logic [2:0] COL_LIM  = 3'(COLS);

    typedef enum logic [2:0] {IDLE, SCAN, WRITE, CHECK, DONE} state_t;
    state_t state_q, state_d;
    logic [2:0] col_q, col_d, row_q, row_d, done_row_q, done_row_d;
    logic [1:0] player_q, player_d, status_q, status_d;
    logic [0:ROWS-1][0:COLS-1][1:0] board_q, board_d;
    logic full_q, full_d;
    logic bad_req;

`ifdef CON4_WIN_CHECK_EN
    logic [1:0] dir_q, dir_d, winner_q, winner_d;
    logic over_q, over_d, hit;
    // dir 0..3 = horizontal, vertical, diagonal, anti-diagonal; walk both ways from the new cell
    always_comb begin : run_count
        int dr, dc, r, c, cnt;
        logic run;
        dr = (dir_q == 2'd0) ? 0 : 1;
        dc = (dir_q == 2'd1) ? 0 : (dir_q == 2'd3) ? -1 : 1;
        cnt = 0;
        for (int s = -1; s <= 1; s += 2) begin
            run = 1'b1;
            for (int k = 1; k < CONNECT; k++) begin
                r = int'(row_q) + s * k * dr;
                c = int'(col_q) + s * k * dc;
                run = run && r >= 0 && r < ROWS && c >= 0 && c < COLS && board_q[3'(r)][3'(c)] == player_q;
                cnt += int'(run);
            end
        end
        hit = cnt + 1 >= CONNECT;
    end
    assign bad_req   = drop_col >= COL_LIM || (drop_player != 2'b01 && drop_player != 2'b10) || over_q;
    assign winner    = winner_q;
    assign game_over = over_q;
`else
    assign bad_req   = drop_col >= COL_LIM || (drop_player != 2'b01 && drop_player != 2'b10);
    assign winner    = 2'b00;
    assign game_over = 1'b0;
`endif

    assign drop_ready  = state_q == IDLE && !clear;
    assign done_valid  = state_q == DONE;
    assign done_status = status_q;
    assign done_row    = done_row_q;
    assign board       = board_q;
    assign board_full  = full_q;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        player_d   = player_q;
        status_d   = status_q;
        done_row_d = done_row_q;
        board_d    = board_q;
`ifdef CON4_WIN_CHECK_EN
        dir_d      = dir_q;
        winner_d   = winner_q;
        over_d     = over_q;
`endif
        case (state_q)
            IDLE: if (drop_valid && drop_ready) begin
                col_d    = drop_col;
                player_d = drop_player;
                row_d    = LAST_ROW;
                state_d  = bad_req ? DONE : SCAN;
                if (bad_req) begin
                    status_d   = 2'b10;
                    done_row_d = 3'd0;
                end
            end
            SCAN: if (board_q[row_q][col_q] == 2'b00) begin
                state_d = WRITE;
            end else if (row_q == 3'd0) begin
                state_d    = DONE;
                status_d   = 2'b01;
                done_row_d = 3'd0;
            end else begin
                row_d = row_q - 3'd1;
            end
            WRITE: begin
                board_d[row_q][col_q] = player_q;
                status_d   = 2'b00;
                done_row_d = row_q;
`ifdef CON4_WIN_CHECK_EN
                state_d    = CHECK;
                dir_d      = 2'd0;
`else
                state_d    = DONE;
`endif
            end
`ifdef CON4_WIN_CHECK_EN
            CHECK: begin
                if (hit) begin
                    winner_d = player_q;
                    over_d   = 1'b1;
                end
                dir_d   = dir_q + 2'd1;
                state_d = (dir_q == 2'd3) ? DONE : CHECK;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort keeps the last reported result; only the board and game flags are wiped
        if (clear) begin
            state_d    = IDLE;
            board_d    = '0;
            status_d   = status_q;
            done_row_d = done_row_q;
`ifdef CON4_WIN_CHECK_EN
            winner_d   = 2'b00;
            over_d     = 1'b0;
`endif
        end
        full_d = 1'b1;
        for (int c = 0; c < COLS; c++) full_d = full_d & (|board_d[0][c]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            player_q   <= '0;
            status_q   <= '0;
            done_row_q <= '0;
            board_q    <= '0;
            full_q     <= 1'b0;
`ifdef CON4_WIN_CHECK_EN
            dir_q      <= '0;
            winner_q   <= '0;
            over_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            player_q   <= player_d;
            status_q   <= status_d;
            done_row_q <= done_row_d;
            board_q    <= board_d;
            full_q     <= full_d;
`ifdef CON4_WIN_CHECK_EN
            dir_q      <= dir_d;
            winner_q   <= winner_d;
            over_q     <= over_d;
`endif
        end
    end
endmodule
